// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch/PC unit: FSM states, default widths
// and the branch-target helper.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        BAR_WAIT = 2'd3
    } pc_state_e;

    localparam int PC_W_DEF  = 10;
    localparam int IMM_W_DEF = 8;

    // Branch target on a 32-bit canvas: pc of the branch + 1 + the
    // already sign-extended word offset. The caller truncates to PC_W.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [31:0] simm);
        return pc + 32'd1 + simm;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_sel.sv
// Combinational next-PC selection: redirect (JALR / taken branch),
// barrier resume point, sequential advance, or hold.
module pc_next_sel
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_accept,
    input  logic             i_exec_valid,
    input  logic [PC_W-1:0]  i_exec_pc,
    input  logic             i_branch,
    input  logic             i_jump_now,
    input  logic [IMM_W-1:0] i_imm,
    input  logic             i_jalr,
    input  logic [31:0]      i_jalr_target,
    input  logic             i_barrier_en,
    output logic [PC_W-1:0]  o_next_pc,
    output logic             o_redirect,
    output logic             o_barrier_take,
    output logic             o_flush,
    output logic [PC_W-1:0]  o_link
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [31:0]     w_imm_sx;
    logic [31:0]     w_epc32;
    logic [31:0]     w_br_tgt32;
    logic [PC_W-1:0] w_br_tgt;
    logic [PC_W-1:0] w_jalr_tgt;
    logic [PC_W-1:0] w_seq_exec;
    logic            w_unused;

    assign w_imm_sx   = {{(32-IMM_W){i_imm[IMM_W-1]}}, i_imm};
    assign w_epc32    = {{(32-PC_W){1'b0}}, i_exec_pc};
    assign w_br_tgt32 = branch_target(w_epc32, w_imm_sx);
    assign w_br_tgt   = w_br_tgt32[PC_W-1:0];
    assign w_jalr_tgt = i_jalr_target[PC_W-1:0];
    assign w_seq_exec = i_exec_pc + PC_ONE;

    // Bits above the PC width wrap away by design.
    assign w_unused = ^{w_br_tgt32[31:PC_W], i_jalr_target[31:PC_W]};

    assign o_link  = w_seq_exec;
    assign o_flush = o_redirect | o_barrier_take;

    // Priority: JALR > taken branch > barrier > sequential accept > hold.
    always_comb begin
        o_next_pc      = i_pc;
        o_redirect     = 1'b0;
        o_barrier_take = 1'b0;
        if (i_exec_valid && i_jalr) begin
            o_next_pc  = w_jalr_tgt;
            o_redirect = 1'b1;
        end else if (i_exec_valid && i_branch && i_jump_now) begin
            o_next_pc  = w_br_tgt;
            o_redirect = 1'b1;
        end else if (i_exec_valid && i_barrier_en) begin
            o_next_pc      = w_seq_exec;
            o_barrier_take = 1'b1;
        end else if (i_accept) begin
            o_next_pc = i_pc + PC_ONE;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch/PC unit: holds the PC, issues imem requests over req/ready,
// hands fetched PCs to decode one cycle later and applies redirects,
// barriers and stalls coming back from execute.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int IMM_W = IMM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    output logic             fetch_valid_o,
    output logic [PC_W-1:0]  fetch_pc_o,
    input  logic             exec_valid_i,
    input  logic [PC_W-1:0]  exec_pc_i,
    input  logic             branch_i,
    input  logic             jump_now_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic             jalr_i,
    input  logic [31:0]      jalr_target_i,
    input  logic             barrier_i,
    input  logic             barrier_release_i,
    output logic             flush_o,
    output logic [PC_W-1:0]  link_o
);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic            r_fv;
    logic [PC_W-1:0] r_fpc;

    logic            w_req;
    logic            w_accept;
    logic            w_bar_en;
    logic [PC_W-1:0] w_next_pc;
    logic            w_redirect;
    logic            w_bar_take;
    logic            w_flush;

    // A barrier only takes effect while the unit is actively fetching or stalled.
    assign w_bar_en = barrier_i && (r_state == RUN || r_state == STALL);
    assign w_accept = w_req && imem_ready_i;

    pc_next_sel #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_next_sel (
        .i_pc           (r_pc),
        .i_accept       (w_accept),
        .i_exec_valid   (exec_valid_i),
        .i_exec_pc      (exec_pc_i),
        .i_branch       (branch_i),
        .i_jump_now     (jump_now_i),
        .i_imm          (imm_i),
        .i_jalr         (jalr_i),
        .i_jalr_target  (jalr_target_i),
        .i_barrier_en   (w_bar_en),
        .o_next_pc      (w_next_pc),
        .o_redirect     (w_redirect),
        .o_barrier_take (w_bar_take),
        .o_flush        (w_flush),
        .o_link         (link_o)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= BOOT;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and request strobe; a barrier released in its own
    // cycle skips BAR_WAIT entirely.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN: begin
                w_req = 1'b1;
                if (w_bar_take)   w_state_nxt = barrier_release_i ? RUN : BAR_WAIT;
                else if (stall_i) w_state_nxt = STALL;
            end
            STALL: begin
                if (w_bar_take)    w_state_nxt = barrier_release_i ? RUN : BAR_WAIT;
                else if (!stall_i) w_state_nxt = RUN;
            end
            BAR_WAIT: begin
                if (barrier_release_i) w_state_nxt = RUN;
            end
            default: w_state_nxt = BOOT;
        endcase
    end

    // PC and decode hand-off. Flushes kill the next fetch_valid; an
    // accept (even in the cycle stall rises) advances and presents the
    // accepted address; a held stall keeps the instruction for decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= '0;
            r_fv  <= 1'b0;
            r_fpc <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_redirect || w_bar_take) begin
                r_fv <= 1'b0;
            end else if (w_accept) begin
                r_fv  <= 1'b1;
                r_fpc <= r_pc;
            end else if (!(r_state == STALL && stall_i)) begin
                r_fv <= 1'b0;
            end
        end
    end

    assign imem_req_o    = w_req;
    assign imem_addr_o   = r_pc;
    assign fetch_valid_o = r_fv;
    assign fetch_pc_o    = r_fpc;
    // Reset outranks any redirect presented in the same cycle.
    assign flush_o       = w_flush && !reset;

endmodule
